rom_load_ctrl: RTL
==================

# rom_load_ctrl

Sequencer between the HPS `ioctl` download stream and the shared ROM write port of the `williams2` core. It decodes each downloaded byte into a ROM region and buffers it until the core grants a write slot, back-pressuring the HPS with `ioctl_wait`. It holds the core in reset during the download and for a fixed time afterwards, and reports the byte count and an additive checksum.

## Interface
Parameters:
- `ROM_INDEX`, 8'd0: `ioctl_index` value that selects ROM download; other indices are ignored.
- `HOLD_CYCLES`, 1024: `clk_sys` cycles the core stays in reset after the download ends (≥1).
- `PROG_END`, 17'h0C000: first address past the program region.
- `SND_END`, 17'h10000: first address past the sound region.
- `GFX_END`, 17'h1C000: first address past the graphics region.
- `DEC_END`, 17'h1C200: first address past the decoder-PROM region.

Ports:
- `clk_sys` in 1: system clock (12 MHz).
- `reset_n` in 1: synchronous reset, active low.
- `ioctl_download` in 1: download active.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_index` in 8: download index.
- `ioctl_addr` in 17: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: HPS must hold the next strobe.
- `slot_free` in 1: core grants the ROM port this cycle.
- `rom_we` out 1: one-cycle write strobe.
- `rom_addr` out 17: write address (absolute).
- `rom_data` out 8: write data.
- `rom_sel` out 4: one-hot region select {DEC,GFX,SND,PROG}, valid with `rom_we`.
- `core_reset_n` out 1: core reset, active low.
- `loaded` out 1: at least one complete download has finished.
- `byte_count` out 17: bytes written in the current or last download.
- `checksum` out 8: mod-256 sum of bytes written.
- `overrun` out 1: sticky; a strobe arrived while the buffer was full.

## Operation
- States: IDLE, LOAD, DRAIN, HOLD, RUN.
  - IDLE is entered from reset.
  - IDLE or RUN → LOAD when `ioctl_download`=1 and `ioctl_index`=`ROM_INDEX`.
  - LOAD → DRAIN when `ioctl_download` falls.
  - DRAIN → HOLD once the buffer is empty (the same cycle if it is already empty).
  - HOLD → RUN after `HOLD_CYCLES` cycles.
  - HOLD → LOAD if a new matching download starts.
- Entering LOAD clears `byte_count`, `checksum` and `overrun`. `loaded` is unchanged.
- `core_reset_n` is 0 in IDLE, LOAD, DRAIN and HOLD, and 1 only in RUN. `loaded` is set on entry to HOLD.
- Buffer: one entry holding addr and data.
  - Filled when `ioctl_wr`=1 in LOAD and `ioctl_index` matches.
  - `ioctl_wait` is a registered copy of the buffer-full flag.
  - A strobe while full is dropped and sets `overrun`.
- Region decode, evaluated at fill time:
  - addr < `PROG_END` → PROG.
  - addr < `SND_END` → SND.
  - addr < `GFX_END` → GFX.
  - addr < `DEC_END` → DEC.
  - otherwise, out of range: the byte is discarded, the buffer stays empty, and the counters are unchanged.
- Issue: when the buffer is full and `slot_free`=1, the next cycle drives `rom_we`=1 with the buffered addr, data and sel. The buffer clears on the same edge. On that edge `byte_count` increments by 1 (saturating at 17'h1FFFF) and `checksum` adds the data mod 256.
- `rom_addr` and `rom_data` hold their last value when `rom_we`=0. `rom_sel`=0 when `rom_we`=0.
- Downloads with a non-matching index are ignored entirely and do not change state.

## Timing
- Reset values: `ioctl_wait`=0, `rom_we`=0, `rom_addr`=0, `rom_data`=0, `rom_sel`=0, `core_reset_n`=0, `loaded`=0, `byte_count`=0, `checksum`=0, `overrun`=0, state IDLE.
- Strobe at cycle t: `ioctl_wait`=1 at t+1.
  - If `slot_free`=1 at t+1, `rom_we`=1 at t+2 and `ioctl_wait`=0 at t+3.
  - Minimum byte spacing is therefore 3 cycles.
- A strobe that arrives in the same cycle the buffer clears counts as full: it is dropped and `overrun` is set. The HPS honoring `ioctl_wait` never produces this case.
- `ioctl_download` falling with the buffer full: the pending write completes in DRAIN before HOLD.
- HOLD counter: HOLD is entered at cycle h and `core_reset_n` rises at h+`HOLD_CYCLES`.
- `reset_n`=0 mid-download aborts at once. The buffer is discarded, no `rom_we` is issued, and all outputs return to reset values on the next edge.

## Structure
- Shared package `williams2_pkg`:
  - region enum and one-hot constants;
  - default region bounds;
  - the `rom_load_ctrl` state typedef.
- A single module, plus one natural sub-module `rom_region_decode` (combinational addr → sel and in-range), which is reused by the core's ROM read path.

## Test plan
- Reset, then a download of bytes 0x11 at 0x00000 and 0x22 at 0x0C000, with `slot_free` held 1:
  - two `rom_we` pulses, with `rom_sel` 4'b0001 then 4'b0010;
  - `byte_count`=2, `checksum`=0x33.
- `slot_free` held 0 for 10 cycles after a strobe:
  - `ioctl_wait` stays 1 and there is no `rom_we`;
  - `slot_free` rises at cycle k → `rom_we` at k+1.
- A second strobe while the buffer is full:
  - it is dropped and `overrun`=1;
  - `byte_count` counts only the first byte.
- A strobe at 0x1C200:
  - no `rom_we`, `ioctl_wait` stays 0, and the counters are unchanged.
- `ioctl_download` falls with one byte pending and `HOLD_CYCLES`=16:
  - the write completes, `loaded`=1, and `core_reset_n` rises 16 cycles after HOLD entry.
- `reset_n` low during LOAD with the buffer full:
  - no write is issued;
  - the next edge gives `core_reset_n`=0, `ioctl_wait`=0 and `loaded`=0.
- A download with index 8'd1:
  - no state change and `core_reset_n` stays 1 in RUN.

Source files
------------

// File: rtl/williams2_pkg.sv
// williams2_pkg
//   Shared types and constants for the williams2 ROM path: region enum,
//   one-hot region selects, default region bounds, and the download
//   sequencer state type.
package williams2_pkg;

  typedef enum logic [1:0] {
    REGION_PROG,
    REGION_SND,
    REGION_GFX,
    REGION_DEC
  } rom_region_t;

  // One-hot selects, bit order {DEC,GFX,SND,PROG}
  localparam logic [3:0] SEL_PROG = 4'b0001;
  localparam logic [3:0] SEL_SND  = 4'b0010;
  localparam logic [3:0] SEL_GFX  = 4'b0100;
  localparam logic [3:0] SEL_DEC  = 4'b1000;

  // Default region bounds (first address past each region)
  localparam logic [16:0] DEF_PROG_END = 17'h0C000;
  localparam logic [16:0] DEF_SND_END  = 17'h10000;
  localparam logic [16:0] DEF_GFX_END  = 17'h1C000;
  localparam logic [16:0] DEF_DEC_END  = 17'h1C200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN
  } load_state_t;

  function automatic logic [3:0] region_sel(input rom_region_t region);
    logic [3:0] sel;
    case (region)
      REGION_PROG: sel = SEL_PROG;
      REGION_SND:  sel = SEL_SND;
      REGION_GFX:  sel = SEL_GFX;
      REGION_DEC:  sel = SEL_DEC;
      default:     sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode
//   Combinational ROM address decoder, shared by the download sequencer
//   and the core's ROM read path.
//   addr     : absolute ROM byte address
//   sel      : one-hot region select {DEC,GFX,SND,PROG}, 0 when out of range
//   in_range : address falls inside one of the four regions
module rom_region_decode
  import williams2_pkg::*;
#(
  parameter logic [16:0] PROG_END = DEF_PROG_END,
  parameter logic [16:0] SND_END  = DEF_SND_END,
  parameter logic [16:0] GFX_END  = DEF_GFX_END,
  parameter logic [16:0] DEC_END  = DEF_DEC_END
) (
  input  logic [16:0] addr,
  output logic [3:0]  sel,
  output logic        in_range
);

  rom_region_t region;

  always_comb begin
    region   = REGION_PROG;
    in_range = 1'b1;
    if (addr < PROG_END) begin
      region = REGION_PROG;
    end else if (addr < SND_END) begin
      region = REGION_SND;
    end else if (addr < GFX_END) begin
      region = REGION_GFX;
    end else if (addr < DEC_END) begin
      region = REGION_DEC;
    end else begin
      in_range = 1'b0;
    end
    sel = in_range ? region_sel(region) : '0;
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl
//   Sequences the HPS ioctl ROM download into the shared ROM write port.
//   Each byte is region-decoded, held in a one-entry buffer until the core
//   grants a slot, and the HPS is throttled with ioctl_wait. The core is
//   held in reset during the download and HOLD_CYCLES afterwards.
//   clk_sys, reset_n          : clock, synchronous active-low reset
//   ioctl_download/wr/index/
//   ioctl_addr/dout           : HPS download stream
//   ioctl_wait                : HPS must hold its next strobe
//   slot_free                 : core grants the ROM write port this cycle
//   rom_we/addr/data/sel      : ROM write port (sel valid with rom_we)
//   core_reset_n              : core reset, released only in RUN
//   loaded                    : a complete download has finished
//   byte_count, checksum      : bytes written and their mod-256 sum
//   overrun                   : sticky, a strobe hit a full buffer
module rom_load_ctrl
  import williams2_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter logic [16:0] PROG_END    = DEF_PROG_END,
  parameter logic [16:0] SND_END     = DEF_SND_END,
  parameter logic [16:0] GFX_END     = DEF_GFX_END,
  parameter logic [16:0] DEC_END     = DEF_DEC_END
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        slot_free,
  output logic        rom_we,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [3:0]  rom_sel,
  output logic        core_reset_n,
  output logic        loaded,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum,
  output logic        overrun
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  load_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;

  logic              buf_full;
  logic [16:0]       buf_addr;
  logic [7:0]        buf_data;
  logic [3:0]        buf_sel;

  logic [3:0]        dec_sel;
  logic              dec_in_range;

  logic              index_match;
  logic              start_load;
  logic              fill_req;
  logic              accept;
  logic              drop;
  logic              issue;
  logic              buf_full_nxt;

  rom_region_decode #(
    .PROG_END (PROG_END),
    .SND_END  (SND_END),
    .GFX_END  (GFX_END),
    .DEC_END  (DEC_END)
  ) u_decode (
    .addr     (ioctl_addr),
    .sel      (dec_sel),
    .in_range (dec_in_range)
  );

  always_comb begin
    index_match  = (ioctl_index == ROM_INDEX);
    start_load   = ioctl_download && index_match &&
                   ((state == ST_IDLE) || (state == ST_HOLD) || (state == ST_RUN));
    fill_req     = (state == ST_LOAD) && ioctl_wr && index_match;
    accept       = fill_req && !buf_full && dec_in_range;
    drop         = fill_req && buf_full;
    issue        = buf_full && slot_free;
    buf_full_nxt = accept || (buf_full && !slot_free);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      buf_full     <= 1'b0;
      buf_addr     <= '0;
      buf_data     <= '0;
      buf_sel      <= '0;
      ioctl_wait   <= 1'b0;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_data     <= '0;
      rom_sel      <= '0;
      core_reset_n <= 1'b0;
      loaded       <= 1'b0;
      byte_count   <= '0;
      checksum     <= '0;
      overrun      <= 1'b0;
    end else begin
      // Wait covers the full buffer plus the write cycle that empties it,
      // so it rises the cycle after a strobe and drops one cycle after rom_we.
      ioctl_wait <= buf_full || buf_full_nxt;
      buf_full   <= buf_full_nxt;

      if (accept) begin
        buf_addr <= ioctl_addr;
        buf_data <= ioctl_dout;
        buf_sel  <= dec_sel;
      end

      rom_we  <= issue;
      rom_sel <= issue ? buf_sel : '0;
      if (issue) begin
        rom_addr <= buf_addr;
        rom_data <= buf_data;
      end

      // The buffer is always empty outside LOAD/DRAIN, so a clear on LOAD
      // entry never collides with a write.
      if (start_load) begin
        byte_count <= '0;
        checksum   <= '0;
        overrun    <= 1'b0;
      end else begin
        if (issue) begin
          if (byte_count != '1) begin
            byte_count <= byte_count + 17'd1;
          end
          checksum <= checksum + buf_data;
        end
        if (drop) begin
          overrun <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_load) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!ioctl_download) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!buf_full) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
            loaded   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (start_load) begin
            state <= ST_LOAD;
          end else if (hold_cnt == '0) begin
            state        <= ST_RUN;
            core_reset_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (start_load) begin
            state        <= ST_LOAD;
            core_reset_n <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          core_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
